// File: rtl/spi_transaction_layer.sv
// Command-level sequencer for an ADS1256-style ADC: expands one command
// into single-byte SPI transfers, owns chip select, waits for DRDY and
// inserts the t6 command-to-read delay between command and data bytes.

package spi_txn_pkg;
    typedef enum logic [2:0] {
        RDATA     = 3'd0,
        RREG      = 3'd1,
        SYNC      = 3'd2,
        WAKEUP    = 3'd3,
        SELFCAL   = 3'd4,
        RESET_CMD = 3'd5
    } transaction_t;
endpackage

module spi_transaction_layer
    import spi_txn_pkg::*;
#(
    parameter int T6_CYCLES = 650
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    output logic         done_o,
    input  transaction_t transaction_i,
    input  logic [3:0]   reg_addr_i,
    output logic         spi_start_o,
    input  logic         spi_done_i,
    output logic         CS_L_o,
    output logic [7:0]   tx_buffer_o,
    input  logic         DRDL_L_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DRDY,
        S_LOAD,
        S_XFER,
        S_DELAY,
        S_FINISH
    } state_t;

    // The counter walks 0..T6_CYCLES-1 and the terminal compare lands one
    // cycle later, so DELAY lasts T6_CYCLES+1 cycles and the next request
    // rises T6_CYCLES+2 cycles after the acknowledge of the command byte.
    localparam logic [15:0] T6_LAST = 16'(T6_CYCLES);

    state_t       state_q, state_d;
    transaction_t cmd_q, cmd_d;
    logic [3:0]   addr_q, addr_d;
    logic [1:0]   idx_q, idx_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         spi_start_q, spi_start_d;
    logic         cs_l_q, cs_l_d;
    logic [7:0]   tx_q, tx_d;
    logic         drdy_meta_q, drdy_sync_q;

    logic [7:0]   cur_byte;
    logic         delay_after;
    logic         last_byte;

    // Number of SPI bytes a command expands into; unknown encodings send none.
    function automatic logic [2:0] byte_count(input transaction_t c);
        case (c)
            RDATA:                              byte_count = 3'd4;
            RREG:                               byte_count = 3'd3;
            SYNC, WAKEUP, SELFCAL, RESET_CMD:   byte_count = 3'd1;
            default:                            byte_count = 3'd0;
        endcase
    endfunction

    // Byte to send for the latched command at the current position.
    always_comb begin
        cur_byte = 8'h00;
        case (cmd_q)
            RDATA:     cur_byte = (idx_q == 2'd0) ? 8'h01 : 8'h00;
            RREG:      cur_byte = (idx_q == 2'd0) ? {4'h1, addr_q} : 8'h00;
            SYNC:      cur_byte = 8'hFC;
            WAKEUP:    cur_byte = 8'h00;
            SELFCAL:   cur_byte = 8'hF0;
            RESET_CMD: cur_byte = 8'hFE;
            default:   cur_byte = 8'h00;
        endcase
    end

    // t6 follows the RDATA opcode and the RREG count byte.
    assign delay_after = ((cmd_q == RDATA) && (idx_q == 2'd0)) ||
                         ((cmd_q == RREG)  && (idx_q == 2'd1));
    assign last_byte   = (({1'b0, idx_q} + 3'd1) == byte_count(cmd_q));

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        spi_start_d = spi_start_q;
        cs_l_d      = cs_l_q;
        tx_d        = tx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cmd_d  = transaction_i;
                    addr_d = reg_addr_i;
                    idx_d  = 2'd0;
                    if (transaction_i == RDATA) begin
                        state_d = S_WAIT_DRDY;
                    end else if (byte_count(transaction_i) == 3'd0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        cs_l_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_WAIT_DRDY: begin
                if (!drdy_sync_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cs_l_d      = 1'b0;
                tx_d        = cur_byte;
                spi_start_d = 1'b1;
                state_d     = S_XFER;
            end
            S_XFER: begin
                if (spi_done_i) begin
                    spi_start_d = 1'b0;
                    if (last_byte) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        cs_l_d  = 1'b1;
                    end else if (delay_after) begin
                        state_d = S_DELAY;
                        cnt_d   = 16'd0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        state_d = S_LOAD;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == T6_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched command, outputs and the two-flop DRDY synchronizer.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cmd_q       <= RDATA;
            addr_q      <= 4'h0;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            done_q      <= 1'b0;
            spi_start_q <= 1'b0;
            cs_l_q      <= 1'b1;
            tx_q        <= 8'h00;
            drdy_meta_q <= 1'b1;
            drdy_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            spi_start_q <= spi_start_d;
            cs_l_q      <= cs_l_d;
            tx_q        <= tx_d;
            drdy_meta_q <= DRDL_L_i;
            drdy_sync_q <= drdy_meta_q;
        end
    end

    assign done_o      = done_q;
    assign spi_start_o = spi_start_q;
    assign CS_L_o      = cs_l_q;
    assign tx_buffer_o = tx_q;

endmodule

// File: tb/tb_spi_transaction_layer.sv
// Bench for spi_transaction_layer: a cycle-level model derived from the
// command byte table and the timing rules, checked every cycle, plus a few
// literal expectations on bytes and gaps.

module tb_spi_transaction_layer;
    import spi_txn_pkg::*;

    localparam int T6 = 650;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic         done_o;
    transaction_t transaction_i = SYNC;
    logic [3:0]   reg_addr_i = 4'h0;
    logic         spi_start_o;
    logic         spi_done_i = 1'b0;
    logic         CS_L_o;
    logic [7:0]   tx_buffer_o;
    logic         DRDL_L_i = 1'b1;

    spi_transaction_layer #(.T6_CYCLES(T6)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .done_o        (done_o),
        .transaction_i (transaction_i),
        .reg_addr_i    (reg_addr_i),
        .spi_start_o   (spi_start_o),
        .spi_done_i    (spi_done_i),
        .CS_L_o        (CS_L_o),
        .tx_buffer_o   (tx_buffer_o),
        .DRDL_L_i      (DRDL_L_i)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Model state
    int           edge_n = 0;
    bit           busy = 0;
    transaction_t m_cmd = SYNC;
    logic [7:0]   exp_q[$];
    bit           dly_q[$];
    bit           in_flight = 0, cur_dly = 0, first_pending = 0, cs_low_exp = 0;
    logic [7:0]   cur_byte = 8'h00;
    int           start_edge = 0, drdy_low_first = -1;
    int           exp_rise = -1, exp_done = -1;
    int           done_count = 0;
    logic [7:0]   req_log[$];
    int           rise_log[$];
    int           sdone_log[$];
    int           done_log[$];
    int           ack_lat = 20;

    // Byte table of each command as the ADC expects it.
    task automatic model_push(input transaction_t c, input logic [3:0] a);
        case (c)
            RDATA: begin
                exp_q.push_back(8'h01); dly_q.push_back(1'b1);
                for (int i = 0; i < 3; i++) begin
                    exp_q.push_back(8'h00); dly_q.push_back(1'b0);
                end
            end
            RREG: begin
                exp_q.push_back({4'h1, a}); dly_q.push_back(1'b0);
                exp_q.push_back(8'h00);     dly_q.push_back(1'b1);
                exp_q.push_back(8'h00);     dly_q.push_back(1'b0);
            end
            SYNC:      begin exp_q.push_back(8'hFC); dly_q.push_back(1'b0); end
            WAKEUP:    begin exp_q.push_back(8'h00); dly_q.push_back(1'b0); end
            SELFCAL:   begin exp_q.push_back(8'hF0); dly_q.push_back(1'b0); end
            RESET_CMD: begin exp_q.push_back(8'hFE); dly_q.push_back(1'b0); end
            default:   ;
        endcase
    endtask

    // Compare process: update the model from inputs seen at each rising
    // edge, then check every output on the following falling edge.
    initial begin
        logic r, s, d, dr;
        transaction_t tc;
        logic [3:0] ta;
        forever begin
            @(posedge clock_i);
            edge_n++;
            r = reset_i; s = start_i; d = spi_done_i; dr = DRDL_L_i;
            tc = transaction_i; ta = reg_addr_i;
            if (r) begin
                busy = 0; in_flight = 0; first_pending = 0; cs_low_exp = 0;
                exp_rise = -1; exp_done = -1; drdy_low_first = -1;
                exp_q.delete(); dly_q.delete();
            end else begin
                if (dr) drdy_low_first = -1;
                else if (drdy_low_first < 0) drdy_low_first = edge_n;
                if (s && !busy) begin
                    busy = 1; m_cmd = tc; start_edge = edge_n;
                    model_push(tc, ta);
                    if (exp_q.size() == 0) exp_done = edge_n;
                    else first_pending = 1;
                end
                if (d && in_flight) begin
                    in_flight = 0;
                    sdone_log.push_back(edge_n);
                    if (exp_q.size() == 0) exp_done = edge_n;
                    else exp_rise = edge_n + (cur_dly ? T6 + 2 : 1);
                end
            end
            @(negedge clock_i);
            if (first_pending) begin
                if (m_cmd == RDATA) begin
                    if (drdy_low_first >= 0)
                        exp_rise = (start_edge + 2 > drdy_low_first + 3) ?
                                   start_edge + 2 : drdy_low_first + 3;
                end else begin
                    exp_rise = start_edge + 1;
                end
            end
            if (edge_n == exp_rise) begin
                in_flight = 1; first_pending = 0; cs_low_exp = 1; exp_rise = -1;
                cur_byte = exp_q.pop_front();
                cur_dly  = dly_q.pop_front();
                rise_log.push_back(edge_n);
                req_log.push_back(tx_buffer_o);
            end
            check("spi_start", spi_start_o, in_flight);
            if (in_flight) check("tx_buffer", tx_buffer_o, cur_byte);
            check("done", done_o, edge_n == exp_done);
            if (edge_n == exp_done) begin
                cs_low_exp = 0; busy = 0; exp_done = -1;
                done_count++; done_log.push_back(edge_n);
            end
            check("cs_l", CS_L_o, !cs_low_exp);
        end
    end

    // Physical-layer stand-in: acknowledge each request ack_lat cycles later.
    initial begin
        forever begin
            @(negedge clock_i);
            if (spi_start_o === 1'b1 && !reset_i) begin
                repeat (ack_lat - 1) @(posedge clock_i);
                #1 spi_done_i = 1'b1;
                @(posedge clock_i);
                #1 spi_done_i = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete(); rise_log.delete(); sdone_log.delete(); done_log.delete();
    endtask

    // Pulse start for one cycle; returns the edge that samples it.
    task automatic do_txn(input transaction_t c, input logic [3:0] a, output int st_edge);
        @(posedge clock_i);
        #1;
        clear_logs();
        transaction_i = c; reg_addr_i = a; start_i = 1'b1;
        st_edge = edge_n + 1;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        transaction_i = SYNC;
        reg_addr_i = 4'hF;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clock_i);
            n++;
        end
        check({name, "_done_seen"}, done_o === 1'b1, 1'b1);
        repeat (3) @(posedge clock_i);
    endtask

    initial begin
        int st, drop_e, dc, n;
        logic [7:0] single_exp[3];
        transaction_t single_cmd[3];

        repeat (2) @(posedge clock_i);
        #1;
        check("rst_tx", tx_buffer_o, 8'h00);
        check("rst_cs", CS_L_o, 1'b1);
        reset_i = 1'b0;

        // RDATA with DRDY held high for 100 ns first.
        do_txn(RDATA, 4'h0, st);
        repeat (9) @(posedge clock_i);
        #1;
        check("rdata_no_req_drdy_high", spi_start_o, 1'b0);
        DRDL_L_i = 1'b0;
        drop_e = edge_n + 1;
        wait_done("rdata", 3000);
        check("rdata_nreq", req_log.size(), 4);
        if (req_log.size() == 4) begin
            check("rdata_b0", req_log[0], 8'h01);
            check("rdata_b1", req_log[1], 8'h00);
            check("rdata_b3", req_log[3], 8'h00);
            check("rdata_drdy_lat", rise_log[0] - drop_e, 3);
            check("rdata_t6_gap", rise_log[1] - sdone_log[0], 652);
            check("rdata_gap_b2", rise_log[2] - sdone_log[1], 1);
        end
        check("rdata_done_count", done_count, 1);

        // Slow acknowledge: request must stay pending for 800 cycles.
        ack_lat = 800;
        do_txn(RDATA, 4'h0, st);
        wait_done("slow", 6000);
        ack_lat = 20;
        if (rise_log.size() >= 2 && sdone_log.size() >= 1) begin
            check("slow_ack_lat", sdone_log[0] - rise_log[0], 800);
            check("slow_t6_gap", rise_log[1] - sdone_log[0], 652);
        end else begin
            check("slow_log_size", rise_log.size(), 4);
        end

        // RREG addr 3; inputs change right after start and must be ignored.
        do_txn(RREG, 4'h3, st);
        wait_done("rreg", 3000);
        check("rreg_nreq", req_log.size(), 3);
        if (req_log.size() == 3) begin
            check("rreg_b0", req_log[0], 8'h13);
            check("rreg_b1", req_log[1], 8'h00);
            check("rreg_b2", req_log[2], 8'h00);
            check("rreg_first_lat", rise_log[0] - st, 1);
            check("rreg_gap1", rise_log[1] - sdone_log[0], 1);
            check("rreg_t6_gap", rise_log[2] - sdone_log[1], 652);
        end

        // SELFCAL: one byte, no DRDY wait, done right after its acknowledge.
        DRDL_L_i = 1'b1;
        do_txn(SELFCAL, 4'h0, st);
        wait_done("selfcal", 500);
        check("selfcal_nreq", req_log.size(), 1);
        if (req_log.size() == 1 && done_log.size() == 1) begin
            check("selfcal_b0", req_log[0], 8'hF0);
            check("selfcal_lat", rise_log[0] - st, 1);
            check("selfcal_done_lat", done_log[0] - sdone_log[0], 0);
        end

        // Remaining single-byte commands.
        single_cmd[0] = SYNC;      single_exp[0] = 8'hFC;
        single_cmd[1] = WAKEUP;    single_exp[1] = 8'h00;
        single_cmd[2] = RESET_CMD; single_exp[2] = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            do_txn(single_cmd[i], 4'h0, st);
            wait_done("single", 500);
            check("single_nreq", req_log.size(), 1);
            if (req_log.size() == 1) check("single_byte", req_log[0], single_exp[i]);
        end

        // Unknown encoding: no bytes, CS stays high, done still pulses.
        do_txn(transaction_t'(3'd7), 4'h0, st);
        wait_done("unknown", 50);
        check("unknown_nreq", req_log.size(), 0);
        if (done_log.size() == 1) check("unknown_done_lat", done_log[0] - st, 0);

        // Reset in the middle of the t6 delay.
        DRDL_L_i = 1'b0;
        do_txn(RDATA, 4'h0, st);
        n = 0;
        while (sdone_log.size() < 1 && n < 2000) begin
            @(negedge clock_i);
            n++;
        end
        check("abort_cmd_acked", sdone_log.size(), 1);
        repeat (100) @(posedge clock_i);
        #1 reset_i = 1'b1;
        dc = done_count;
        @(posedge clock_i);
        #1 reset_i = 1'b0;
        @(negedge clock_i);
        check("abort_cs_high", CS_L_o, 1'b1);
        check("abort_no_req", spi_start_o, 1'b0);
        repeat (1000) @(posedge clock_i);
        check("abort_no_done", done_count - dc, 0);
        do_txn(RDATA, 4'h0, st);
        wait_done("after_abort", 3000);
        check("after_abort_nreq", req_log.size(), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
